// File: rtl/alfa_pc_pkg.sv
// Definitions shared by the occupancy-code reader and writer: state encoding,
// default DDR region base and the byte/word counter widths.
package alfa_pc_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_STREAM = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

  localparam logic [31:0] DDR_BASE_ADDRESS_DEF = 32'h0F00_0000;

  localparam int BYTE_CNT_W = 32;
  // 29 bits of 64-bit word index keeps (wordCnt << 3) inside a 32-bit address.
  localparam int WORD_CNT_W = 29;

  function automatic logic [31:0] wordAddr(input logic [31:0]           base,
                                           input logic [WORD_CNT_W-1:0] wordCnt);
    return base + {wordCnt, 3'b000};
  endfunction

endpackage

// File: rtl/occ_word_serializer.sv
// Holds one 64-bit DDR word and hands it out LSB byte first over a
// valid/ready handshake; last_o marks the top byte of the word.
module occ_word_serializer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        load_i,
  input  logic [63:0] word_i,
  input  logic        en_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [63:0] word_q;
  logic [2:0]  byteIdx_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      word_q    <= '0;
      byteIdx_q <= '0;
    end else if (load_i) begin
      word_q    <= word_i;
      byteIdx_q <= '0;
    end else if (valid_o && ready_i) begin
      byteIdx_q <= byteIdx_q + 3'd1;
    end
  end

  assign valid_o = en_i;
  assign byte_o  = en_i ? word_q[{byteIdx_q, 3'b000} +: 8] : 8'h00;
  assign last_o  = (byteIdx_q == 3'd7);

endmodule

// File: rtl/occ_code_reader.sv
// Fetches occupancy bytes from DDR one 64-bit word at a time and streams them
// to the BFS decoder. Define OCC_READER_TIMEOUT_EN to enable the WAIT timeout.
module occ_code_reader
  import alfa_pc_pkg::*;
#(
  parameter logic [31:0] DDR_BASE_ADDRESS = DDR_BASE_ADDRESS_DEF,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BYTE_CNT_W-1:0] i_n_bytes,
  output logic [31:0]           o_read_address,
  output logic                  o_initreadtxn,
  input  logic                  i_read_TxnDone,
  input  logic [63:0]           i_read_data,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  logic [STATE_W-1:0]    state_q,     state_d;
  logic [BYTE_CNT_W-1:0] bytesLeft_q, bytesLeft_d;
  logic [WORD_CNT_W-1:0] wordCnt_q,   wordCnt_d;
  logic [31:0]           readAddr_q,  readAddr_d;

  logic wordLoad;
  logic byteFire;
  logic lastByte;
  logic timeoutHit;

  assign wordLoad = (state_q == ST_WAIT) && i_read_TxnDone;
  assign byteFire = o_byte_valid && i_byte_ready;

  occ_word_serializer u_serializer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load_i  (wordLoad),
    .word_i  (i_read_data),
    .en_i    (state_q == ST_STREAM),
    .ready_i (i_byte_ready),
    .byte_o  (o_byte),
    .valid_o (o_byte_valid),
    .last_o  (lastByte)
  );

  always_comb begin
    state_d     = state_q;
    bytesLeft_d = bytesLeft_q;
    wordCnt_d   = wordCnt_q;
    readAddr_d  = readAddr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bytesLeft_d = i_n_bytes;
          wordCnt_d   = '0;
          if (i_n_bytes != '0) begin
            readAddr_d = wordAddr(DDR_BASE_ADDRESS, '0);
            state_d    = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_read_TxnDone) begin
          state_d = ST_STREAM;
        end else if (timeoutHit) begin
          state_d = ST_DONE;
        end
      end
      ST_STREAM: begin
        // Ending on the byte count drops whatever is left of a partial word.
        if (byteFire) begin
          bytesLeft_d = bytesLeft_q - BYTE_CNT_W'(1);
          if (bytesLeft_q == BYTE_CNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (lastByte) begin
            wordCnt_d  = wordCnt_q + WORD_CNT_W'(1);
            readAddr_d = wordAddr(DDR_BASE_ADDRESS, wordCnt_q + WORD_CNT_W'(1));
            state_d    = ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      bytesLeft_q <= '0;
      wordCnt_q   <= '0;
      readAddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      bytesLeft_q <= bytesLeft_d;
      wordCnt_q   <= wordCnt_d;
      readAddr_q  <= readAddr_d;
    end
  end

`ifdef OCC_READER_TIMEOUT_EN
  logic [31:0] waitCnt_q;
  logic        err_q;

  // waitCnt_q holds the number of WAIT cycles already spent before this one.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      waitCnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      waitCnt_q <= waitCnt_q + 32'd1;
    end else begin
      waitCnt_q <= '0;
    end
  end

  assign timeoutHit = (state_q == ST_WAIT) && (waitCnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      err_q <= 1'b0;
    end else if (timeoutHit && !i_read_TxnDone) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign timeoutHit = 1'b0;
  assign o_err      = 1'b0;
`endif

  assign o_read_address = readAddr_q;
  assign o_initreadtxn  = (state_q == ST_REQ);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_occ_code_reader.sv
// Directed self-checking bench for occ_code_reader; the timeout section is
// built only when OCC_READER_TIMEOUT_EN is defined.
module tb_occ_code_reader;

  localparam logic [31:0] BASE = 32'h0F00_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_n_bytes;
  logic [31:0] o_read_address;
  logic        o_initreadtxn;
  logic        i_read_TxnDone;
  logic [63:0] i_read_data;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] wordMem [0:3];

  occ_code_reader #(
    .DDR_BASE_ADDRESS (BASE),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_n_bytes      (i_n_bytes),
    .o_read_address (o_read_address),
    .o_initreadtxn  (o_initreadtxn),
    .i_read_TxnDone (i_read_TxnDone),
    .i_read_data    (i_read_data),
    .o_byte         (o_byte),
    .o_byte_valid   (o_byte_valid),
    .i_byte_ready   (i_byte_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [31:0] nBytes);
    i_start   = start;
    i_n_bytes = nBytes;
    tick();
    i_start   = 1'b0;
  endtask

  // Runs one fetch, serving each DDR read two cycles late, and checks bytes,
  // addresses and completion timing against wordMem.
  task automatic runTransfer(input int nBytes, input bit stall);
    int   byteCount  = 0;
    int   wordIdx    = 0;
    int   cycles     = 0;
    int   reqCount   = 0;
    int   lastFire   = -10;
    int   firstValid = -1;
    bit   finished   = 1'b0;
    logic [63:0] curWord;
    logic [7:0]  expByte;
    i_byte_ready = 1'b1;
    applyStimulus(1'b1, nBytes);
    checkOutput("busy_after_start", {63'd0, o_busy}, 64'd1);
    while (!finished && cycles < 500) begin
      if (o_initreadtxn) begin
        reqCount++;
        checkOutput("read_addr", o_read_address, {32'd0, BASE + 32'(wordIdx * 8)});
        tick(); cycles++;
        checkOutput("req_one_cycle", {63'd0, o_initreadtxn}, 64'd0);
        applyStimulus(1'b1, 32'd1);
        cycles++;
        checkOutput("addr_hold", o_read_address, {32'd0, BASE + 32'(wordIdx * 8)});
        checkOutput("no_valid_in_wait", {63'd0, o_byte_valid}, 64'd0);
        i_read_TxnDone = 1'b1;
        i_read_data    = wordMem[wordIdx];
        tick(); cycles++;
        i_read_TxnDone = 1'b0;
        i_read_data    = 64'hDEAD_BEEF_CAFE_F00D;
        checkOutput("valid_latency", {63'd0, o_byte_valid}, 64'd1);
        wordIdx++;
      end else if (o_byte_valid) begin
        if (firstValid < 0) firstValid = cycles;
        curWord = wordMem[byteCount / 8];
        expByte = curWord[8 * (byteCount % 8) +: 8];
        checkOutput("byte", {56'd0, o_byte}, {56'd0, expByte});
        i_byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i_byte_ready) begin
          byteCount++;
          lastFire = cycles;
        end
        tick(); cycles++;
      end else if (o_done) begin
        checkOutput("byte_count", 64'(byteCount), 64'(nBytes));
        checkOutput("done_timing", 64'(cycles), (nBytes == 0) ? 64'd0 : 64'(lastFire + 1));
        finished = 1'b1;
      end else begin
        tick(); cycles++;
      end
    end
    checkOutput("transfer_bounded", {63'd0, finished}, 64'd1);
    checkOutput("read_count", 64'(reqCount), 64'((nBytes + 7) / 8));
    if (!stall && nBytes > 0 && nBytes <= 8)
      checkOutput("consecutive_bytes", 64'(lastFire - firstValid), 64'(nBytes - 1));
    i_byte_ready = 1'b1;
    tick();
    checkOutput("done_one_cycle", {63'd0, o_done}, 64'd0);
    checkOutput("idle_after_done", {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    wordMem[0] = 64'h0807_0605_0403_0201;
    wordMem[1] = 64'hA5A4_A3A2_A10B_0A09;
    wordMem[2] = 64'h1817_1615_1413_1211;
    wordMem[3] = 64'h2827_2625_2423_2221;
    i_rst          = 1'b0;
    i_start        = 1'b0;
    i_n_bytes      = 32'd0;
    i_read_TxnDone = 1'b0;
    i_read_data    = 64'd0;
    i_byte_ready   = 1'b1;
    tick();
    tick();
    checkOutput("rst_initreadtxn", {63'd0, o_initreadtxn}, 64'd0);
    checkOutput("rst_byte_valid", {63'd0, o_byte_valid}, 64'd0);
    checkOutput("rst_byte", {56'd0, o_byte}, 64'd0);
    checkOutput("rst_read_address", {32'd0, o_read_address}, 64'd0);
    checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("rst_done", {63'd0, o_done}, 64'd0);
    checkOutput("rst_err", {63'd0, o_err}, 64'd0);
    i_rst = 1'b1;
    tick();

    $display("[TB] single full word");
    runTransfer(8, 1'b0);
    $display("[TB] partial second word");
    wordMem[1] = 64'hA5A4_A3A2_A10B_0A09;
    runTransfer(11, 1'b0);
    $display("[TB] zero-length request");
    runTransfer(0, 1'b0);
    $display("[TB] random ready stalls");
    runTransfer(20, 1'b1);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 32'd8);
    checkOutput("abort_req", {63'd0, o_initreadtxn}, 64'd1);
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    i_read_TxnDone = 1'b1;
    i_read_data    = wordMem[0];
    tick();
    i_read_TxnDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort_no_done", {63'd0, o_done}, 64'd0);
      checkOutput("abort_no_byte", {63'd0, o_byte_valid}, 64'd0);
      checkOutput("abort_idle", {63'd0, o_busy}, 64'd0);
      tick();
    end
    checkOutput("abort_addr_cleared", {32'd0, o_read_address}, 64'd0);

`ifdef OCC_READER_TIMEOUT_EN
    $display("[TB] WAIT timeout");
    applyStimulus(1'b1, 32'd8);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput("timeout_wait_no_done", {63'd0, o_done}, 64'd0);
      tick();
    end
    checkOutput("timeout_done", {63'd0, o_done}, 64'd1);
    checkOutput("timeout_err", {63'd0, o_err}, 64'd1);
    tick();
    checkOutput("timeout_err_sticky", {63'd0, o_err}, 64'd1);
    checkOutput("timeout_idle", {63'd0, o_busy}, 64'd0);
    applyStimulus(1'b1, 32'd0);
    checkOutput("err_cleared_on_start", {63'd0, o_err}, 64'd0);
    tick();
`else
    $display("[TB] WAIT persists without timeout");
    applyStimulus(1'b1, 32'd8);
    tick();
    for (int i = 0; i < 40; i++) tick();
    checkOutput("wait_persist_busy", {63'd0, o_busy}, 64'd1);
    checkOutput("wait_persist_no_done", {63'd0, o_done}, 64'd0);
    checkOutput("wait_persist_no_err", {63'd0, o_err}, 64'd0);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
